// File: rtl/uart_rx_deframer_if.sv
// Serial-line side and host-side signals of the 8E1 UART receiver.
// Latency: none, wiring only.
// Backpressure: none; rx_valid is a strobe and the consumer must take it.
interface uart_rx_deframer_if;
    logic       rxd;
    logic       rx_en;
    logic [2:0] baud_select;
    logic [7:0] rx_data;
    logic       rx_ferror;
    logic       rx_perror;
    logic       rx_valid;
    logic       rx_busy;

    // Drives the line and the controls (bench or upstream wrapper).
    modport master (
        output rxd, rx_en, baud_select,
        input  rx_data, rx_ferror, rx_perror, rx_valid, rx_busy
    );

    // The receiver itself.
    modport slave (
        input  rxd, rx_en, baud_select,
        output rx_data, rx_ferror, rx_perror, rx_valid, rx_busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// 8E1 UART receiver: 16x oversampling, 3-sample majority, even-parity and stop checks.
// Latency: rx_valid ~2 + 170*div clks after the start falling edge (middle of the stop bit).
// Backpressure: none; one-cycle rx_valid strobe, data and sticky flags hold until next frame.
module uart_rx_deframer #(
    parameter int CLK_HZ    = 50000000,
    parameter int DATA_BITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    uart_rx_deframer_if.slave  bus
);

    localparam int BCW = $clog2(DATA_BITS);

    // Clocks per 1/16 bit, rounded to nearest.
    function automatic logic [13:0] baud_div(input int baud);
        return 14'((CLK_HZ + 8 * baud) / (16 * baud));
    endfunction

    localparam logic [13:0] DIV_300    = baud_div(300);
    localparam logic [13:0] DIV_1200   = baud_div(1200);
    localparam logic [13:0] DIV_4800   = baud_div(4800);
    localparam logic [13:0] DIV_9600   = baud_div(9600);
    localparam logic [13:0] DIV_19200  = baud_div(19200);
    localparam logic [13:0] DIV_38400  = baud_div(38400);
    localparam logic [13:0] DIV_57600  = baud_div(57600);
    localparam logic [13:0] DIV_115200 = baud_div(115200);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_q, state_d;
    logic                   sync1, rxs;
    logic [2:0]             baud_q;
    logic [13:0]            div_cnt, div_max;
    logic [3:0]             s_cnt;
    logic [BCW-1:0]         bit_cnt;
    logic                   smp7, smp8;
    logic [DATA_BITS-1:0]   shreg;
    logic                   perr_q;
    logic                   tick, maj, at9, at15;
    logic                   start_frame, done;

    // Two-flop synchroniser; presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= bus.rxd;
            rxs   <= sync1;
        end
    end

    // Divisor for the rate latched at frame start.
    always_comb begin
        div_max = DIV_115200;
        case (baud_q)
            3'b000:  div_max = DIV_300;
            3'b001:  div_max = DIV_1200;
            3'b010:  div_max = DIV_4800;
            3'b011:  div_max = DIV_9600;
            3'b100:  div_max = DIV_19200;
            3'b101:  div_max = DIV_38400;
            3'b110:  div_max = DIV_57600;
            default: div_max = DIV_115200;
        endcase
    end

    assign tick = (state_q != IDLE) && (div_cnt == div_max - 14'd1);
    assign at9  = tick && (s_cnt == 4'd9);
    assign at15 = tick && (s_cnt == 4'd15);
    // Third vote is the live sample at s=9, so the bit is decided on that tick.
    assign maj  = (smp7 & smp8) | (smp7 & rxs) | (smp8 & rxs);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; STOP leaves at its s=9 vote so the next start edge is not missed.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        done        = 1'b0;
        if (!bus.rx_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d     = START;
                        start_frame = 1'b1;
                    end
                end
                START: begin
                    if (at9 && maj) begin
                        state_d = IDLE;
                    end else if (at15) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (at15 && (bit_cnt == BCW'(DATA_BITS - 1))) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    if (at15) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (at9) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Tick/sample/bit counters and the data path; everything is parked at zero in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_q  <= 3'b000;
            div_cnt <= '0;
            s_cnt   <= '0;
            bit_cnt <= '0;
            smp7    <= 1'b1;
            smp8    <= 1'b1;
            shreg   <= '0;
            perr_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            div_cnt <= '0;
            s_cnt   <= '0;
            bit_cnt <= '0;
            if (start_frame) begin
                baud_q <= bus.baud_select;
            end
        end else begin
            div_cnt <= tick ? 14'd0 : div_cnt + 14'd1;
            if (tick) begin
                s_cnt <= s_cnt + 4'd1;
            end
            if (tick && (s_cnt == 4'd7)) begin
                smp7 <= rxs;
            end
            if (tick && (s_cnt == 4'd8)) begin
                smp8 <= rxs;
            end
            if (at15 && (state_q == DATA)) begin
                bit_cnt <= bit_cnt + BCW'(1);
            end
            if (at9 && (state_q == DATA)) begin
                shreg <= {maj, shreg[DATA_BITS-1:1]};
            end
            if (at9 && (state_q == PARITY)) begin
                perr_q <= (^shreg) ^ maj;
            end
        end
    end

    // Host-side outputs: updated only by a completed frame, errors included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rx_data   <= '0;
            bus.rx_perror <= 1'b0;
            bus.rx_ferror <= 1'b0;
            bus.rx_valid  <= 1'b0;
        end else begin
            bus.rx_valid <= done;
            if (done) begin
                bus.rx_data   <= shreg;
                bus.rx_perror <= perr_q;
                bus.rx_ferror <= ~maj;
            end
        end
    end

    assign bus.rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for the 8E1 receiver: frames, errors, glitches, aborts, skew.
// Latency: checks are taken after each frame has fully gone out on the line.
// Backpressure: none; a monitor captures every rx_valid pulse.
module tb_uart_rx_deframer;

    localparam int BIT111 = 27 * 16;
    localparam int BIT011 = 326 * 16;

    logic clk;
    logic reset;

    uart_rx_deframer_if bus();

    uart_rx_deframer #(.CLK_HZ(50000000), .DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         vcnt   = 0;
    int         vhi    = 0;
    logic       vprev  = 1'b0;
    logic [7:0] cap_dat [16];
    logic       cap_pe  [16];
    logic       cap_fe  [16];

    // Capture every rx_valid pulse and count cycles it is high.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            vhi++;
            if (!vprev) begin
                if (vcnt < 16) begin
                    cap_dat[vcnt] = bus.rx_data;
                    cap_pe[vcnt]  = bus.rx_perror;
                    cap_fe[vcnt]  = bus.rx_ferror;
                end
                vcnt++;
            end
        end
        vprev = (bus.rx_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    // Drive the first nbits of {stop, parity, data, start} LSB first, then idle high.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int bclk, input int nbits);
        logic [10:0] f;
        f = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.rxd = f[i];
            clocks(bclk);
        end
        bus.rxd = 1'b1;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            if (bus.rx_busy === 1'b0) break;
            clocks(1);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #(200000 * 20);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.rxd         = 1'b1;
        bus.rx_en       = 1'b0;
        bus.baud_select = 3'b000;
        clocks(4);
        check("rst_data",  32'(bus.rx_data),   32'h0);
        check("rst_valid", 32'(bus.rx_valid),  32'h0);
        check("rst_ferr",  32'(bus.rx_ferror), 32'h0);
        check("rst_perr",  32'(bus.rx_perror), 32'h0);
        check("rst_busy",  32'(bus.rx_busy),   32'h0);
        reset           = 1'b0;
        bus.rx_en       = 1'b1;
        bus.baud_select = 3'b111;
        clocks(10);

        // Clean 0xDD at 115200.
        send_frame(8'hDD, 1'b0, 1'b1, BIT111, 11);
        clocks(10);
        check("dd_cnt",   32'(vcnt), 32'd1);
        check("dd_width", 32'(vhi),  32'd1);
        check("dd_data",  32'(bus.rx_data),   32'hDD);
        check("dd_perr",  32'(bus.rx_perror), 32'h0);
        check("dd_ferr",  32'(bus.rx_ferror), 32'h0);
        check("dd_busy",  32'(bus.rx_busy),   32'h0);

        // 0x01 with wrong parity bit.
        send_frame(8'h01, 1'b0, 1'b1, BIT111, 11);
        clocks(10);
        check("p01_cnt",  32'(vcnt), 32'd2);
        check("p01_data", 32'(bus.rx_data),   32'h01);
        check("p01_perr", 32'(bus.rx_perror), 32'h1);
        check("p01_ferr", 32'(bus.rx_ferror), 32'h0);

        // Good 0x55 sent 3% fast clears the parity flag.
        send_frame(8'h55, even_par(8'h55), 1'b1, 419, 11);
        clocks(10);
        check("f55_cnt",  32'(vcnt), 32'd3);
        check("f55_data", 32'(bus.rx_data),   32'h55);
        check("f55_perr", 32'(bus.rx_perror), 32'h0);

        // Back-to-back frames, no idle gap.
        send_frame(8'h12, even_par(8'h12), 1'b1, BIT111, 11);
        send_frame(8'h34, even_par(8'h34), 1'b1, BIT111, 11);
        clocks(10);
        check("b2b_cnt",   32'(vcnt), 32'd5);
        check("b2b_width", 32'(vhi),  32'd5);
        check("b2b_d0",    32'(cap_dat[3]), 32'h12);
        check("b2b_d1",    32'(cap_dat[4]), 32'h34);
        check("b2b_pe1",   32'(cap_pe[4]),  32'h0);
        check("b2b_fe1",   32'(cap_fe[4]),  32'h0);

        // 0xA5 at 9600 with stop bit low; the low stop re-arms START, which must self-reject.
        bus.baud_select = 3'b011;
        clocks(4);
        send_frame(8'hA5, even_par(8'hA5), 1'b0, BIT011, 11);
        wait_idle(4000);
        check("a5_cnt",  32'(vcnt), 32'd6);
        check("a5_data", 32'(bus.rx_data),   32'hA5);
        check("a5_ferr", 32'(bus.rx_ferror), 32'h1);
        check("a5_perr", 32'(bus.rx_perror), 32'h0);
        check("a5_busy", 32'(bus.rx_busy),   32'h0);

        // Good 0x3C at 115200 sent 3% slow clears the framing flag.
        bus.baud_select = 3'b111;
        clocks(4);
        send_frame(8'h3C, even_par(8'h3C), 1'b1, 445, 11);
        clocks(10);
        check("s3c_cnt",  32'(vcnt), 32'd7);
        check("s3c_data", 32'(bus.rx_data),   32'h3C);
        check("s3c_ferr", 32'(bus.rx_ferror), 32'h0);

        // 3-clk glitch: START entered, then rejected.
        bus.rxd = 1'b0;
        clocks(3);
        bus.rxd = 1'b1;
        clocks(4);
        check("gl_busy_on",  32'(bus.rx_busy), 32'h1);
        clocks(300);
        check("gl_busy_off", 32'(bus.rx_busy), 32'h0);
        check("gl_cnt",      32'(vcnt), 32'd7);
        check("gl_data",     32'(bus.rx_data), 32'h3C);

        // Half-bit low pulse: also rejected.
        bus.rxd = 1'b0;
        clocks(216);
        bus.rxd = 1'b1;
        clocks(100);
        check("hb_busy", 32'(bus.rx_busy), 32'h0);
        check("hb_cnt",  32'(vcnt), 32'd7);
        check("hb_ferr", 32'(bus.rx_ferror), 32'h0);

        // rx_en dropped mid-DATA discards the frame; then 0xF0 is received.
        send_frame(8'hAA, even_par(8'hAA), 1'b1, BIT111, 2);
        check("en_busy_mid", 32'(bus.rx_busy), 32'h1);
        bus.rx_en = 1'b0;
        clocks(2);
        check("en_busy_off", 32'(bus.rx_busy), 32'h0);
        bus.rx_en = 1'b1;
        clocks(2);
        send_frame(8'hF0, even_par(8'hF0), 1'b1, BIT111, 11);
        clocks(10);
        check("f0_cnt",  32'(vcnt), 32'd8);
        check("f0_data", 32'(bus.rx_data),   32'hF0);
        check("f0_perr", 32'(bus.rx_perror), 32'h0);
        check("f0_ferr", 32'(bus.rx_ferror), 32'h0);

        // Reset mid-DATA clears outputs immediately.
        send_frame(8'h77, even_par(8'h77), 1'b1, BIT111, 2);
        check("rm_busy_mid", 32'(bus.rx_busy), 32'h1);
        reset = 1'b1;
        #1;
        check("rm_data",  32'(bus.rx_data),   32'h0);
        check("rm_valid", 32'(bus.rx_valid),  32'h0);
        check("rm_busy",  32'(bus.rx_busy),   32'h0);
        check("rm_perr",  32'(bus.rx_perror), 32'h0);
        check("rm_ferr",  32'(bus.rx_ferror), 32'h0);
        clocks(3);
        reset = 1'b0;
        clocks(5);
        check("rm_busy_after", 32'(bus.rx_busy), 32'h0);
        check("rm_cnt",        32'(vcnt), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Receive end of the team's 8E1 UART link: recovers frames driven by the UART transmitter on a serial line. Uses 16x oversampling with 3-sample majority voting and checks even parity and the stop bit. Presents each byte on a one-cycle valid strobe with sticky error flags. Sits between the serial pin and the host-side consumer, on the same 50 MHz clock as the transmitter.

Parameters:
CLK_HZ, 50000000, system clock frequency; the divisor table below is correct only at this value.
DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
clk  input  1  system clock, 50 MHz, rising edge.
reset  input  1  asynchronous, active-high reset.
rx_data  output  8  last received byte, LSB first on the wire.
baud_select  input  3  rate select: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
rx_en  input  1  receiver enable.
rxd  input  1  serial line; idles high; asynchronous to clk.
rx_ferror  output  1  stop bit sampled low in last frame.
rx_perror  output  1  even-parity mismatch in last frame.
rx_valid  output  1  one-cycle strobe: rx_data and error flags updated.
rx_busy  output  1  frame reception in progress (FSM not in IDLE).

Behaviour:
- Reset (async, any time): rx_data=0, rx_valid=0, rx_ferror=0, rx_perror=0, rx_busy=0. FSM goes to IDLE, counters clear, both synchroniser flops preset to 1.
- Synchroniser: rxd passes through 2 flops; all logic uses the synchronised value rxs.
- Tick generator: divisor per baud_select is 10417, 2604, 651, 326, 163, 81, 54, 27 (= CLK_HZ/(16*baud), rounded). Counter runs 0..div-1 and pulses tick for one clk at div-1.
  - Counter is held at 0 in IDLE.
  - baud_select is latched on entry to START; changes mid-frame have no effect until the next frame.
- Sample counter s runs 0..15 and increments on each tick. Bit value = majority of rxs at s=7,8,9. Bit ends at the tick where s=15.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if rx_en=1 and rxs=0, go to START and clear counters.
  - START: evaluate majority at s=9. If the majority is 1 (false start/glitch), return to IDLE with no output change. Otherwise continue and, at s=15, go to DATA.
  - DATA: shift the majority bit into bit 7 of a shift register (LSB arrives first). After 8 bits, go to PARITY.
  - PARITY: perr = XOR(8 data bits, parity bit); even parity requires 0. Go to STOP.
  - STOP: on the clk after the s=9 evaluation:
    - rx_data <= shift register; rx_perror <= perr; rx_ferror <= (stop majority==0).
    - rx_valid=1 for exactly that one clk.
    - Go to IDLE immediately, without waiting for s=15, so back-to-back frames and the next start edge are accepted.
  - Data and flags update even when an error is flagged.
- Flags and rx_data hold until the next completed frame. Aborted frames leave them unchanged.
- rx_en=0: FSM is forced to IDLE on the next clk, including mid-frame; the frame is discarded and no rx_valid is produced. Outputs hold their values.
- rx_busy = (state != IDLE).
- Latency: rx_valid asserts 2 (sync) + (10*16+10)*div clks after the falling edge, +/-1 clk. At 111 (div 27) that is about 4590 clks (91.8 us).
- Line stuck low after a frame: the FSM re-enters START, and the stop bit of that frame reads 0 -> rx_ferror=1. No lockup.

Test Plan:
- Reset, then baud 111: feed 0xDD framed as start 0, bits 1,0,1,1,1,0,1,1, parity 0, stop 1 at 27*16 clk/bit -> one rx_valid pulse, rx_data=0xDD, rx_perror=0, rx_ferror=0, rx_busy low after.
- Baud 111, byte 0x01 with parity bit 0 (wrong; even parity requires 1) -> rx_valid, rx_data=0x01, rx_perror=1, rx_ferror=0. The next good frame 0x55 (parity 0) clears rx_perror.
- Baud 011 (div 326), byte 0xA5 with stop bit driven 0 -> rx_data=0xA5, rx_ferror=1. Then the line returns high, a glitch-free 0x3C is sent, and rx_ferror clears.
- A 3-clk low glitch on an idle line, and a half-bit low pulse -> both rejected at start validation: no rx_valid, rx_busy returns to 0, outputs unchanged.
- Two back-to-back frames 0x12, 0x34 with zero idle gap at 111 -> two rx_valid pulses with the correct bytes. Also sample rxd with a +/-3% baud skew -> bytes still correct.
- Assert reset mid-DATA: all outputs 0 immediately. Separately, drop rx_en mid-frame -> no rx_valid. Re-enable rx_en, send 0xF0 -> received correctly.
